// File: rtl/led_scroll_driver.sv
// Multiplexed N-digit 7-segment driver scrolling a writable circular hex message.
// Each digit slot blanks all anodes for BLANK_CYCLES before lighting one anode.
module led_scroll_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int MSG_DEPTH    = 16,
  parameter int REFRESH_DIV  = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int SCROLL_DIV   = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [3:0]                   wr_data,
  input  logic                         scroll_en,
  input  logic                         step,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [$clog2(MSG_DEPTH)-1:0] ptr_out
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(SCROLL_DIV);

  logic [CW-1:0]         c_q, c_d;
  logic [DW-1:0]         d_q, d_d;
  logic [AW-1:0]         p_q, p_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [3:0]            mem_q [MSG_DEPTH];
  logic [3:0]            mem_d [MSG_DEPTH];
  logic [AW-1:0]         idx;
  logic                  slot_end;
  logic                  lit;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    slot_end = (c_q == CW'(REFRESH_DIV - 1));
    c_d      = slot_end ? '0 : c_q + 1'b1;
    d_d      = d_q;
    if (slot_end) d_d = (d_q == '0) ? DW'(NUM_DIGITS - 1) : d_q - 1'b1;

    // Leftmost digit (highest d) shows mem[p]; index wraps naturally at MSG_DEPTH.
    idx   = p_q + AW'(NUM_DIGITS - 1) - AW'(d_q);
    seg_d = seg_q;
    dp_d  = dp_q;
    if (c_q == '0) begin
      seg_d = hex7(mem_q[idx]);
      dp_d  = (idx != '0);
    end

    lit = (c_q >= CW'(BLANK_CYCLES));
    for (int k = 0; k < NUM_DIGITS; k++) an_d[k] = ~(lit && (d_q == DW'(k)));

    p_d   = p_q;
    tmr_d = '0;
    if (scroll_en) begin
      if (tmr_q == TW'(SCROLL_DIV - 1)) p_d = p_q + 1'b1;
      else tmr_d = tmr_q + 1'b1;
    end else if (step) begin
      p_d = p_q + 1'b1;
    end

    for (int i = 0; i < MSG_DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q   <= '0;
      d_q   <= DW'(NUM_DIGITS - 1);
      p_q   <= '0;
      tmr_q <= '0;
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= 4'(i);
    end else begin
      c_q   <= c_d;
      d_q   <= d_d;
      p_q   <= p_d;
      tmr_q <= tmr_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign ptr_out = p_q;

endmodule

// File: tb/tb_led_scroll_driver.sv
// Scoreboard bench for led_scroll_driver: expected lit slots are queued by the
// stimulus and checked by a monitor at each slot's first lit cycle.
module tb_led_scroll_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       scroll_en = 1'b0;
  logic       step = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] ptr_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [11:0] exp_q [$];

  led_scroll_driver #(
    .NUM_DIGITS(4), .MSG_DEPTH(16), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SCROLL_DIV(64)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scroll_en(scroll_en), .step(step), .an(an), .seg(seg), .dp(dp), .ptr_out(ptr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_q.push_back({a, s, d});
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_an(input logic [3:0] target, input int limit);
    int n = 0;
    while (an !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_an", an, target);
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  // Checks one-hot anodes, stable seg/dp while lit, slot timing, and queued slot contents.
  task automatic monitor();
    logic       prev_lit = 1'b0;
    logic [3:0] prev_an = '1;
    logic [6:0] prev_seg = '1;
    logic       prev_dp = 1'b1;
    bit         seen = 1'b0;
    int         lit_len = 0;
    int         blank_len = 0;
    logic       now_lit;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_lit = 1'b0; seen = 1'b0; lit_len = 0; blank_len = 0;
      end else begin
        now_lit = (an !== 4'b1111);
        chk("one_anode", 32'($countones(~an) <= 1), 1);
        if (now_lit && prev_lit) begin
          chk("seg_stable", {an, seg, dp}, {prev_an, prev_seg, prev_dp});
          lit_len++;
        end else if (now_lit) begin
          if (seen) chk("blank_len", blank_len, 2);
          if (exp_q.size() != 0) chk("slot", {an, seg, dp}, exp_q.pop_front());
          lit_len = 1;
        end else if (prev_lit) begin
          chk("lit_len", lit_len, 6);
          seen = 1'b1;
          blank_len = 1;
        end else begin
          blank_len++;
        end
        prev_lit = now_lit;
      end
      prev_an = an; prev_seg = seg; prev_dp = dp;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values and release sequence
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_ptr", ptr_out, 0);
    for (int r = 0; r < 2; r++) begin
      push(4'b0111, 7'b0000001, 1'b0);
      push(4'b1011, 7'b1001111, 1'b1);
      push(4'b1101, 7'b0010010, 1'b1);
      push(4'b1110, 7'b0000110, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rel_blank0", an, 4'b1111);
    chk("rel_seg0", seg, 7'b0000001);
    chk("rel_dp0", dp, 0);
    @(negedge clk);
    chk("rel_blank1", an, 4'b1111);
    @(negedge clk);
    chk("rel_first_lit", an, 4'b0111);
    wait_drain(100);

    // Mid-slot writes appear only from the next slot on
    write(4'h0, 4'hA); write(4'h1, 4'hB); write(4'h2, 4'hC); write(4'h3, 4'hD);
    push(4'b0111, 7'b0001000, 1'b0);
    push(4'b1011, 7'b1100000, 1'b1);
    push(4'b1101, 7'b0110001, 1'b1);
    push(4'b1110, 7'b1000010, 1'b1);
    wait_drain(60);
    write(4'h0, 4'h0); write(4'h1, 4'h1); write(4'h2, 4'h2); write(4'h3, 4'h3);

    // Auto scroll, then stop at p=13 and check wrap-around window
    scroll_en = 1'b1;
    repeat (63) @(negedge clk);
    chk("scroll_before", ptr_out, 0);
    @(negedge clk);
    chk("scroll_first", ptr_out, 1);
    repeat (12 * 64) @(negedge clk);
    chk("scroll_13", ptr_out, 13);
    scroll_en = 1'b0;
    wait_an(4'b1110, 40);
    @(negedge clk);
    push(4'b0111, 7'b1000010, 1'b1);
    push(4'b1011, 7'b0110000, 1'b1);
    push(4'b1101, 7'b0111000, 1'b1);
    push(4'b1110, 7'b0000001, 1'b0);
    wait_drain(60);
    chk("hold_13", ptr_out, 13);
    scroll_en = 1'b1;
    repeat (3 * 64 - 1) @(negedge clk);
    chk("scroll_15", ptr_out, 15);
    @(negedge clk);
    chk("scroll_wrap", ptr_out, 0);
    scroll_en = 1'b0;

    // Manual step mode
    pulse_step();
    chk("step_one", ptr_out, 1);
    pulse_step();
    pulse_step();
    chk("step_three", ptr_out, 3);
    wait_an(4'b1110, 40);
    @(negedge clk);
    push(4'b0111, 7'b0000110, 1'b1);
    push(4'b1011, 7'b1001100, 1'b1);
    push(4'b1101, 7'b0100100, 1'b1);
    push(4'b1110, 7'b0100000, 1'b1);
    wait_drain(60);
    scroll_en = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    scroll_en = 1'b0;
    @(negedge clk);
    chk("step_ignored", ptr_out, 3);

    // Reset in the middle of a lit slot
    write(4'h0, 4'hE);
    wait_an(4'b1011, 40);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp, 1);
    chk("mid_rst_ptr", ptr_out, 0);
    repeat (2) @(negedge clk);
    push(4'b0111, 7'b0000001, 1'b0);
    push(4'b1011, 7'b1001111, 1'b1);
    push(4'b1101, 7'b0010010, 1'b1);
    push(4'b1110, 7'b0000110, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_blank", an, 4'b1111);
    wait_drain(60);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
